addr_tx_state_machine: RTL and testbench
========================================

# addr_tx_state_machine

Serial address transmitter for the system bus. It takes a parallel address from a local requester and performs the valid/ready handshake with the receiving slave. It then shifts the address out LSB-first on a single serial line. It sits on the master side of the address channel and drives the serial stream that the slave-side address receiver reassembles into a parallel address.

## Interface
- ADDR_WIDTH, 12, number of address bits serialised per transfer (≥2)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately
- start  input  1  request to send; sampled only in IDLE
- addr_in  input  ADDR_WIDTH  address to send; captured on the accepted start edge
- ready  input  1  slave ready; sampled only in REQ
- valid  output  1  transfer request to slave, registered
- tx_address  output  1  serial address bit, registered
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the last bit has been sent

## Operation
- States: IDLE, REQ, SHIFT, DONE, plus PAR when PARITY is compiled in.
- IDLE: valid=0, tx_address=0, busy=0. If start=1 at an edge, latch addr_in into the shift register, clear the bit counter, and go to REQ.
- REQ: valid=1, tx_address=addr[0]. Both are held for as long as ready=0. There is no timeout.
- REQ exit: ready=1 at an edge means addr[0] has been transferred in that cycle. Shift right, set counter=1, and go to SHIFT.
- SHIFT: valid=0, tx_address=addr[counter]. One bit is sent per cycle and the counter increments.
- SHIFT exit: after addr[ADDR_WIDTH-1] is sent, go to PAR if parity is enabled, otherwise go to DONE.
- PAR: valid=0, tx_address = XOR of all ADDR_WIDTH latched bits (even parity). Lasts one cycle, then goes to DONE.
- DONE: done=1, tx_address=0, valid=0. Lasts one cycle, then goes to IDLE.
- start outside IDLE is ignored. addr_in changes after capture have no effect.
- ready outside REQ is ignored.
- Counter width is clog2(ADDR_WIDTH). It saturates at the final bit and never wraps mid-transfer.
- Reset (reset=0) at any time: go to IDLE immediately, clear the shift register and counter, force all outputs to 0. A partial transfer is abandoned and done is not pulsed.

## Timing
- Reset values: valid=0, tx_address=0, busy=0, done=0.
- All outputs are registered and change only on rising clk edges, except during asynchronous reset.
- start accepted at edge N → valid=1 and tx_address=bit0 during cycle N..N+1.
- Ready high in the first REQ cycle (edge N+1) → bits 1..ADDR_WIDTH-1 on cycles N+1..N+ADDR_WIDTH-1.
- That case, without parity → done high during cycle N+ADDR_WIDTH..N+ADDR_WIDTH+1.
- With parity, the parity bit takes one extra cycle and done shifts one cycle later.
- Each cycle of ready=0 in REQ adds one cycle to all later events.
- busy rises the cycle after start and falls the cycle after done.
- The earliest next accepted start is at the edge where DONE → IDLE plus one, i.e. the first edge that samples IDLE.

## Configuration
- ADDR_TX_PARITY_EN defined: the PAR state exists and an even-parity bit is sent after the MSB. Transfer length is ADDR_WIDTH+1 serial bits.
- ADDR_TX_PARITY_EN undefined: there is no PAR state and SHIFT goes directly to DONE. Transfer length is ADDR_WIDTH bits, which matches the existing receiver.

## Test plan
- Reset: hold reset=0 for 3 cycles with start=1 → valid, tx_address, busy, done all 0 throughout, and no transfer starts.
- addr_in=0xA5C, ready held 1 → valid high 1 cycle. tx_address sequence is 0,0,1,1,1,0,1,0,0,1,0,1. done pulses 1 cycle after the last bit.
- addr_in=0x001, ready asserted 3 cycles after valid → valid high 4 cycles with tx_address=1 held. Then bits 0×11, then done.
- start pulsed again mid-SHIFT with addr_in=0xFFF → ignored. The original stream completes unchanged and exactly one done pulse is produced.
- reset=0 asserted asynchronously after 5 bits → outputs go to 0 immediately. The next start sends the full new address from bit 0.
- With ADDR_TX_PARITY_EN: 0x001 → 12 data bits then parity bit 1; 0xA5C → parity bit 0. In both cases done follows the parity bit by one cycle.

Source files
------------

// File: rtl/addr_tx_state_machine.sv
// Serial address transmitter: valid/ready handshake on bit 0, then LSB-first shift of the rest.
// Latency: bit 0 the cycle after start, one bit per cycle after ready; backpressure: REQ holds while ready=0.
// Optional even-parity bit after the MSB when ADDR_TX_PARITY_EN is defined.
module addr_tx_state_machine #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  ready,
    output logic                  valid,
    output logic                  tx_address,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(ADDR_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(ADDR_WIDTH - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
`ifdef ADDR_TX_PARITY_EN
    localparam logic [2:0] PAR   = 3'd4;
`endif

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef ADDR_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    // tx_d is the bit that will be on the line during the next state, so the
    // outputs stay registered while tracking the state transition exactly.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        tx_d    = 1'b0;
`ifdef ADDR_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    sh_d    = addr_in;
                    cnt_d   = '0;
                    tx_d    = addr_in[0];
`ifdef ADDR_TX_PARITY_EN
                    par_d   = ^addr_in;
`endif
                end
            end
            REQ: begin
                if (ready) begin
                    state_d = SHIFT;
                    sh_d    = sh_q >> 1;
                    cnt_d   = CW'(1);
                    tx_d    = sh_q[1];
                end else begin
                    tx_d    = sh_q[0];
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_BIT) begin
`ifdef ADDR_TX_PARITY_EN
                    state_d = PAR;
                    tx_d    = par_q;
`else
                    state_d = DONE;
`endif
                end else begin
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                    tx_d  = sh_q[1];
                end
            end
`ifdef ADDR_TX_PARITY_EN
            PAR:     state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == REQ);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ADDR_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ADDR_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign valid      = valid_q;
    assign tx_address = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_addr_tx_state_machine.sv
// Directed bench for addr_tx_state_machine: reset, held/delayed ready, ignored start, async abort.
module tb_addr_tx_state_machine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [11:0] addr_in = '0;
    logic        ready = 1'b0;
    logic        valid, tx_address, busy, done;

    int errors = 0;
    int checks = 0;

    // 0xA5C LSB first, worked out by hand from the hex digits C,5,A
    logic seq_a5c [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    addr_tx_state_machine #(.ADDR_WIDTH(12)) dut (
        .clk(clk), .reset(reset), .start(start), .addr_in(addr_in), .ready(ready),
        .valid(valid), .tx_address(tx_address), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; addr_in = 12'hA5C; ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({valid, tx_address, busy, done} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d outs(v,tx,b,d)=%b want 0000", i, {valid, tx_address, busy, done});
            end
        end
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({valid, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL reset_release cyc=%0d outs(v,b,d)=%b want 000", i, {valid, busy, done});
            end
        end
    endtask

    task automatic test_ready_held();
        addr_in = 12'hA5C; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0; addr_in = 12'h000;
        checks++;
        if ({valid, tx_address, busy, done} !== {1'b1, seq_a5c[0], 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL held_req outs(v,tx,b,d)=%b want %b", {valid, tx_address, busy, done}, {1'b1, seq_a5c[0], 2'b10});
        end
        for (int i = 1; i < 12; i++) begin
            tick();
            checks++;
            if ({valid, tx_address, busy, done} !== {1'b0, seq_a5c[i], 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL held_bit%0d outs(v,tx,b,d)=%b want %b", i, {valid, tx_address, busy, done}, {1'b0, seq_a5c[i], 2'b10});
            end
        end
`ifdef ADDR_TX_PARITY_EN
        tick();
        checks++;
        if ({valid, tx_address, done} !== 3'b000) begin
            errors++;
            $display("FAIL held_parity outs(v,tx,d)=%b want 000", {valid, tx_address, done});
        end
`endif
        tick();
        checks++;
        if ({valid, tx_address, busy, done} !== 4'b0011) begin
            errors++;
            $display("FAIL held_done outs(v,tx,b,d)=%b want 0011", {valid, tx_address, busy, done});
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL held_idle outs(b,d)=%b want 00", {busy, done});
        end
        ready = 1'b0;
    endtask

    task automatic test_ready_delay();
        addr_in = 12'h001; start = 1'b1; ready = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({valid, tx_address, busy} !== 3'b111) begin
                errors++;
                $display("FAIL delay_req cyc=%0d outs(v,tx,b)=%b want 111", k, {valid, tx_address, busy});
            end
            if (k == 3) ready = 1'b1;
            tick();
        end
        ready = 1'b0;
        for (int i = 1; i < 12; i++) begin
            checks++;
            if ({valid, tx_address, done} !== 3'b000) begin
                errors++;
                $display("FAIL delay_bit%0d outs(v,tx,d)=%b want 000", i, {valid, tx_address, done});
            end
            tick();
        end
`ifdef ADDR_TX_PARITY_EN
        checks++;
        if ({valid, tx_address, done} !== 3'b010) begin
            errors++;
            $display("FAIL delay_parity outs(v,tx,d)=%b want 010", {valid, tx_address, done});
        end
        tick();
`endif
        checks++;
        if ({valid, tx_address, done} !== 3'b001) begin
            errors++;
            $display("FAIL delay_done outs(v,tx,d)=%b want 001", {valid, tx_address, done});
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        addr_in = 12'hA5C; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 12; i++) begin
            if (i == 5) begin start = 1'b1; addr_in = 12'hFFF; end
            if (i == 7) start = 1'b0;
            tick();
            checks++;
            if ({valid, tx_address} !== {1'b0, seq_a5c[i]}) begin
                errors++;
                $display("FAIL ignore_bit%0d outs(v,tx)=%b want %b", i, {valid, tx_address}, {1'b0, seq_a5c[i]});
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) dones++;
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL ignore_restart cyc=%0d valid=%b want 0", i, valid);
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ignore_done_count got=%0d want 1", dones);
        end
        ready = 1'b0;
    endtask

    task automatic test_async_reset();
        addr_in = 12'hA5C; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        checks++;
        if ({busy, tx_address} !== {1'b1, seq_a5c[4]}) begin
            errors++;
            $display("FAIL abort_pre outs(b,tx)=%b want %b", {busy, tx_address}, {1'b1, seq_a5c[4]});
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({valid, tx_address, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_immediate outs(v,tx,b,d)=%b want 0000", {valid, tx_address, busy, done});
        end
        tick();
        checks++;
        if ({valid, tx_address, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_hold outs(v,tx,b,d)=%b want 0000", {valid, tx_address, busy, done});
        end
        reset = 1'b1;
        tick();
        addr_in = 12'h001; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({valid, tx_address, busy} !== 3'b111) begin
            errors++;
            $display("FAIL abort_new_bit0 outs(v,tx,b)=%b want 111", {valid, tx_address, busy});
        end
        for (int i = 1; i < 12; i++) begin
            tick();
            checks++;
            if ({valid, tx_address, done} !== 3'b000) begin
                errors++;
                $display("FAIL abort_new_bit%0d outs(v,tx,d)=%b want 000", i, {valid, tx_address, done});
            end
        end
`ifdef ADDR_TX_PARITY_EN
        tick();
`endif
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL abort_new_done done=%b want 1", done);
        end
        ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_ready_held();
        test_ready_delay();
        test_start_ignored();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
